// File: rtl/latch_array_pkg.sv
// Types and constants shared by the latch-array access sequencer, the address
// decoder and the bitcell array.
package latch_array_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int ADDR_W    = 3;
  localparam int NUM_WORDS = 8;

  localparam logic R_W_READ  = 1'b0;
  localparam logic R_W_WRITE = 1'b1;

endpackage

// File: rtl/cycle_down_counter.sv
// Loadable down-counter with a zero flag. It parks at zero rather than
// wrapping, so a stray decrement cannot restart a phase.
module cycle_down_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/latch_array_access_ctrl.sv
// Glitch-safe single-word access sequencer in front of the 3-to-8 decoder:
// address settles with E low, E pulses, E drops, then the address may move.
//
// state | meaning
// IDLE  | ready for a request; E low, last address/data held
// SETUP | address, r_w and wdata settling with E low
// PULSE | E high, word line active
// HOLD  | E low again, address held one more cycle, resp_valid high
module latch_array_access_ctrl
  import latch_array_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              adr0,
  output logic              adr1,
  output logic              adr2,
  output logic              E,
  output logic              r_w,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata
);

  localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  if (SETUP_CYC < 1 || PULSE_CYC < 1) begin : g_bad_params
    $error("latch_array_access_ctrl: SETUP_CYC and PULSE_CYC must both be >= 1");
  end

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] adr_q, adr_nxt;
  logic              e_nxt, r_w_nxt, resp_valid_nxt;
  logic [DATA_W-1:0] wdata_nxt, resp_rdata_nxt;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]  cnt_load_val;

  cycle_down_counter #(.WIDTH(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign req_ready = (state == IDLE);
  assign {adr2, adr1, adr0} = adr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      adr_q      <= '0;
      E          <= 1'b0;
      r_w        <= R_W_READ;
      wdata      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state      <= state_nxt;
      adr_q      <= adr_nxt;
      E          <= e_nxt;
      r_w        <= r_w_nxt;
      wdata      <= wdata_nxt;
      resp_valid <= resp_valid_nxt;
      resp_rdata <= resp_rdata_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    adr_nxt        = adr_q;
    r_w_nxt        = r_w;
    wdata_nxt      = wdata;
    e_nxt          = 1'b0;
    resp_valid_nxt = 1'b0;
    resp_rdata_nxt = resp_rdata;
    cnt_load       = 1'b0;
    cnt_load_val   = '0;
    cnt_dec        = 1'b0;

    case (state)
      IDLE: begin
        if (req_valid) begin
          adr_nxt      = req_addr;
          r_w_nxt      = req_we;
          wdata_nxt    = req_wdata;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(SETUP_CYC - 1);
          state_nxt    = SETUP;
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          e_nxt        = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(PULSE_CYC - 1);
          state_nxt    = PULSE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      PULSE: begin
        if (cnt_zero) begin
          // rdata is sampled on the edge that drops E, while the word line is still driven
          if (r_w == R_W_READ) resp_rdata_nxt = rdata;
          resp_valid_nxt = 1'b1;
          state_nxt      = HOLD;
        end else begin
          e_nxt   = 1'b1;
          cnt_dec = 1'b1;
        end
      end
      HOLD: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_latch_array_access_ctrl.sv
// Directed bench for latch_array_access_ctrl: default timing instance plus a
// SETUP_CYC=3 / PULSE_CYC=1 instance sharing clock and reset.
`timescale 1ns/1ps
module tb_latch_array_access_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_we;
  logic [2:0] req_addr;
  logic [3:0] req_wdata, rdata;
  logic       req_ready, resp_valid, adr0, adr1, adr2, E, r_w;
  logic [3:0] resp_rdata, wdata;

  logic       req_valid_b, req_we_b;
  logic [2:0] req_addr_b;
  logic [3:0] req_wdata_b, rdata_b;
  logic       req_ready_b, resp_valid_b, adr0_b, adr1_b, adr2_b, e_b, r_w_b;
  logic [3:0] resp_rdata_b, wdata_b;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         e_rises = 0;
  logic       mon_en = 1'b0;
  logic       prev_e = 1'b0;
  logic [7:0] prev_bus = '0;
  logic [3:0] exp_rdata = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  latch_array_access_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .adr0(adr0), .adr1(adr1), .adr2(adr2), .E(E), .r_w(r_w),
    .wdata(wdata), .rdata(rdata)
  );

  latch_array_access_ctrl #(.DATA_W(4), .SETUP_CYC(3), .PULSE_CYC(1)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_we(req_we_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b),
    .adr0(adr0_b), .adr1(adr1_b), .adr2(adr2_b), .E(e_b), .r_w(r_w_b),
    .wdata(wdata_b), .rdata(rdata_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // adr/r_w/wdata must not move in a cycle where E is high or has just fallen
  always @(negedge clk) begin
    if (mon_en && !rst && (E || prev_e))
      check("bus_stable_around_e", 32'({adr2, adr1, adr0, r_w, wdata}), 32'(prev_bus));
    if (E && !prev_e) e_rises++;
    prev_e   = E;
    prev_bus = {adr2, adr1, adr0, r_w, wdata};
  end

  // One full request on the default instance, checked cycle by cycle.
  task automatic run_req(input logic we, input logic [2:0] addr,
                         input logic [3:0] wd, input logic [3:0] rd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; rdata = rd;
    check("ready_before_accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    if (!we) exp_rdata = rd;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wd; req_we = ~we;
      end
      if (c == 4) rdata = ~rd;
      check("e_seq",      32'(E),          32'(c == 2 || c == 3));
      check("resp_valid", 32'(resp_valid), 32'(c == 4));
      check("req_ready",  32'(req_ready),  32'(c == 5));
      check("adr_held",   32'({adr2, adr1, adr0}), 32'(addr));
      check("r_w_held",   32'(r_w),        32'(we));
      check("wdata_held", 32'(wdata),      32'(wd));
      if (c == 4) check("resp_rdata", 32'(resp_rdata), 32'(exp_rdata));
    end
  endtask

  initial begin
    int e0, t_prev;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rdata = '0;
    req_valid_b = 1'b0; req_we_b = 1'b0; req_addr_b = '0; req_wdata_b = '0; rdata_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_outs",  32'({adr2, adr1, adr0, E, r_w, wdata, resp_valid, resp_rdata}), 32'd0);
    check("rst_ready_b", 32'(req_ready_b), 32'd1);
    mon_en = 1'b1;

    // write then read of word 5
    run_req(1'b1, 3'd5, 4'hA, 4'h0);
    run_req(1'b0, 3'd5, 4'h0, 4'hA);
    run_req(1'b1, 3'd2, 4'h3, 4'h7);   // write leaves resp_rdata at 4'hA
    run_req(1'b0, 3'd0, 4'hF, 4'h6);

    // continuous req_valid across all eight words
    e0 = e_rises;
    t_prev = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd0; req_wdata = 4'd3; rdata = 4'h9;
    for (int i = 0; i < 8; i++) begin
      check("cont_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      if (i > 0) check("cont_spacing", 32'(cyc - t_prev), 32'd5);
      t_prev = cyc;
      @(negedge clk);
      if (i < 7) begin
        req_we = ~req_we; req_addr = 3'(i + 1); req_wdata = 4'(i + 4);
      end else begin
        req_valid = 1'b0;
      end
      check("cont_adr", 32'({adr2, adr1, adr0}), 32'(i));
      check("cont_r_w", 32'(r_w), 32'(i % 2));
      for (int c = 2; c <= 4; c++) begin
        @(negedge clk);
        check("cont_busy", 32'(req_ready), 32'd0);
      end
      @(negedge clk);
    end
    exp_rdata = 4'h9;
    check("cont_e_pulses", 32'(e_rises - e0), 32'd8);
    check("cont_last_read", 32'(resp_rdata), 32'(exp_rdata));

    // request raised while busy is held off and then taken with its own fields
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd3; req_wdata = 4'h6;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_we = 1'b1; req_addr = 3'd6; req_wdata = 4'h9;
      end
      check("busy_not_ready", 32'(req_ready), 32'd0);
      check("busy_adr_a",     32'({adr2, adr1, adr0, wdata}), 32'({3'd3, 4'h6}));
    end
    @(negedge clk);
    check("busy_ready_again", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("busy_adr_b", 32'({adr2, adr1, adr0, r_w, wdata}), 32'({3'd6, 1'b1, 4'h9}));
    repeat (3) @(negedge clk);
    check("busy_b_resp", 32'(resp_valid), 32'd1);
    @(negedge clk);

    // reset in the middle of a pulse
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd7; rdata = 4'hC;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_e", 32'(E), 32'd1);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_e",    32'(E), 32'd0);
    check("async_rst_outs", 32'({adr2, adr1, adr0, r_w, wdata, resp_valid, resp_rdata}), 32'd0);
    check("async_rst_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("post_rst_quiet", 32'({resp_valid, E, req_ready}), 32'b001);
    end
    mon_en = 1'b1;

    // SETUP_CYC=3, PULSE_CYC=1 instance
    @(negedge clk);
    req_valid_b = 1'b1; req_we_b = 1'b1; req_addr_b = 3'd4; req_wdata_b = 4'h5;
    check("b_ready", 32'(req_ready_b), 32'd1);
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) req_valid_b = 1'b0;
      check("b_e_seq",      32'(e_b),          32'(c == 4));
      check("b_resp_valid", 32'(resp_valid_b), 32'(c == 5));
      check("b_req_ready",  32'(req_ready_b),  32'(c == 6));
      check("b_adr",        32'({adr2_b, adr1_b, adr0_b, r_w_b, wdata_b}), 32'({3'd4, 1'b1, 4'h5}));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/latch_array_access_ctrl.md
Name: latch_array_access_ctrl

Overview:
Sequencer directly upstream of the 3-to-8 address decoder in the 8-word NAND-latch bitcell array.
- Accepts single-word read/write requests over a valid/ready handshake.
- Drives adr0/adr1/adr2, decoder enable E, r_w and write data with a glitch-safe sequence: the address settles with E low, E pulses, then E drops before the address may change.
- Captures read data and returns a one-cycle response.

Parameters:
DATA_W, 4, width of one latch word
SETUP_CYC, 1, cycles the address and r_w are stable with E=0 before the pulse (>=1)
PULSE_CYC, 2, cycles E is held high (>=1)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept; high only in IDLE
req_we  in  1  1=write, 0=read
req_addr  in  3  word address; bit 0 is LSB
req_wdata  in  DATA_W  write data
resp_valid  out  1  one-cycle completion pulse, for reads and writes
resp_rdata  out  DATA_W  read data, valid while resp_valid=1
adr0  out  1  req_addr[0] to decoder
adr1  out  1  req_addr[1] to decoder
adr2  out  1  req_addr[2] to decoder
E  out  1  decoder enable, word-line pulse
r_w  out  1  1=write, 0=read, to array
wdata  out  DATA_W  data to array bitlines
rdata  in  DATA_W  data from array

Behaviour:
- All outputs except req_ready are registered.
- req_ready = (state==IDLE), decoded combinationally from the state register.
- Reset, asynchronous: state=IDLE; adr0..2=0, E=0, r_w=0, wdata=0, resp_valid=0, resp_rdata=0, counter=0. req_ready=1 after reset.
- Reset mid-operation: E falls immediately. The in-flight request is abandoned with no resp_valid.
- FSM states: IDLE, SETUP, PULSE, HOLD.
- IDLE:
  - On req_valid & req_ready, latch req_addr onto adr0..2, req_we onto r_w and req_wdata onto wdata.
  - Load the counter with SETUP_CYC-1 and go to SETUP.
  - When no request is taken, outputs hold their last values with E=0.
- SETUP: E=0 and the address is stable. When the counter reaches 0, set E=1, load PULSE_CYC-1 and go to PULSE. Otherwise decrement the counter.
- PULSE: E=1. When the counter reaches 0:
  - Set E=0.
  - If r_w=0, sample rdata into resp_rdata.
  - Set resp_valid=1 and go to HOLD.
  - Otherwise decrement the counter.
- HOLD: E=0, with address, r_w and wdata still held. Clear resp_valid and go to IDLE.
- Latency: from the accept edge to the resp_valid cycle is SETUP_CYC+PULSE_CYC cycles (3 with defaults). resp_valid is high during the first HOLD cycle.
- Occupancy: one request every SETUP_CYC+PULSE_CYC+2 cycles (5 with defaults). There is no back-to-back skip of IDLE.
- E invariant: E is high only in PULSE. adr0..2, r_w and wdata never change in the cycle E is high or in the cycle E falls.
- Writes: resp_rdata keeps its previous value.
- req_valid while busy is ignored (req_ready=0). The requester must hold its request until accepted.
- Counter width: $clog2(max(SETUP_CYC,PULSE_CYC)+1). An elaboration check rejects SETUP_CYC<1 or PULSE_CYC<1.

Decomposition:
- Shared package latch_array_pkg holds:
  - state enum (IDLE, SETUP, PULSE, HOLD)
  - ADDR_W=3 and NUM_WORDS=8 constants, shared with the decoder and the array
  - R_W_READ=0 and R_W_WRITE=1 encodings
- One sub-module is natural: cycle_down_counter, a loadable down-counter with a zero flag, instanced once and reused by SETUP and PULSE.

Test Plan:
- Write addr=5, data=4'hA (defaults) -> adr2..0=101 and r_w=1 from cycle 1. E=1 in cycles 2-3, E=0 in cycle 4. resp_valid only in cycle 4. req_ready returns in cycle 5.
- Read addr=5 with rdata driven 4'hA -> resp_valid and resp_rdata=4'hA in the same cycle. r_w=0 throughout.
- Continuous req_valid over addr 0..7 -> accepted exactly every 5 cycles. Exactly one E pulse per request. Bench assertion: adr0..2 never changes while E=1 or on the E falling edge.
- Request arriving during SETUP/PULSE -> not accepted (req_ready=0). Held request is accepted in the next IDLE cycle with its own addr/data.
- rst asserted in the middle of a PULSE cycle -> E=0 and all outputs at reset values without waiting for a clock edge. No resp_valid. req_ready=1 after release.
- SETUP_CYC=3, PULSE_CYC=1 -> E low for 3 cycles after accept, high 1 cycle. resp_valid at accept+4.
